// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: bus widths and the
// transfer state encoding.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int APB_PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired flags the ACCESS cycle whose
// stall would bring the count up to TIMEOUT (never asserted when TIMEOUT=0).
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational look-ahead so the bridge leaves ACCESS after exactly TIMEOUT stalls.
  assign expired = (TIMEOUT != 0) && enable && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB4 master, one transfer outstanding,
// with a wait-state timeout so a hung slave cannot stall the requester.
//
// state  | meaning
// IDLE   | ready for a request; bus idle
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// RESP   | response held until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_strb,
  input  logic [APB_PROT_W-1:0] req_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_STRB_W-1:0] PSTRB,
  output logic [APB_PROT_W-1:0] PPROT,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e state;
  logic       accept;
  logic       timer_en;
  logic       expired;

  assign req_ready = (state == IDLE) && !PRESET;
  assign accept    = req_valid && req_ready;
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign timer_en  = (state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (accept),
    .enable (timer_en),
    .expired(expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PSTRB  <= req_write ? req_strb : '0;
            PPROT  <= req_prot;
            state  <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          // A completing slave takes priority over a timeout in the same cycle.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            state     <= RESP;
          end else if (expired) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT=4: a table of
// transfers with a scripted slave, plus reset and back-to-back sequences.
module tb_apb_master_bridge;

  localparam int T = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;      // stall cycles before PREADY; large = never ready
    logic [31:0] prdata;
    logic        slverr;
    int          exp_access;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;       // cycles with rsp_ready=0 before consuming
  } vec_t;

  vec_t vec[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int acc;
    bit done;
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb; req_prot = v.prot;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_req_ready", 32'(req_ready), 32'd0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", 32'(PWRITE), 32'(v.write));
    chk("setup_pstrb", 32'(PSTRB), v.write ? 32'(v.strb) : 32'd0);
    chk("setup_pprot", 32'(PPROT), 32'(v.prot));
    if (v.write) chk("setup_pwdata", PWDATA, v.wdata);
    acc = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        chk("access_psel", 32'(PSEL & PENABLE), 32'd1);
        chk("access_paddr", PADDR, v.addr);
        PREADY  = (acc == v.waits);
        PRDATA  = (acc == v.waits) ? v.prdata : 32'hFFFF_FFFF;
        PSLVERR = (acc == v.waits) ? v.slverr : 1'b1;
        acc++;
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("access_cycles", 32'(acc), 32'(v.exp_access));
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("resp_psel", 32'(PSEL | PENABLE | req_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, v.exp_rdata);
      chk("hold_err", 32'(rsp_err), 32'(v.exp_err));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("after_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    vec[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0,  32'hAAAA5555, 1'b0, 1, 32'h0,        1'b0, 0};
    vec[1] = '{1'b0, 32'h20, 32'h11111111, 4'hF, 3'd2, 3,  32'h12345678, 1'b0, 4, 32'h12345678, 1'b0, 0};
    vec[2] = '{1'b0, 32'h24, 32'h0,        4'hF, 3'd1, 1,  32'hCAFEF00D, 1'b1, 2, 32'hCAFEF00D, 1'b1, 4};
    vec[3] = '{1'b0, 32'h30, 32'h0,        4'h0, 3'd0, 99, 32'h77777777, 1'b0, 4, 32'h0,        1'b1, 1};
    vec[4] = '{1'b1, 32'h44, 32'h01020304, 4'h3, 3'd4, 99, 32'h77777777, 1'b0, 4, 32'h0,        1'b1, 0};
    vec[5] = '{1'b1, 32'h50, 32'hA5A5A5A5, 4'h5, 3'd7, 2,  32'h99999999, 1'b1, 3, 32'h0,        1'b1, 0};
    vec[6] = '{1'b0, 32'h60, 32'h0,        4'hF, 3'd3, 2,  32'h0BADCAFE, 1'b0, 3, 32'h0BADCAFE, 1'b0, 2};

    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ctrl", 32'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pstrb_pprot", 32'({PSTRB, PPROT}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    PRESET = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    // Reset pulsed while the slave is stalling in ACCESS.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h5; req_strb = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_access", 32'(PSEL & PENABLE), 32'd1);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    PRESET = 1'b0;
    chk("mid_rst_bus", 32'({PSEL, PENABLE}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    run_txn(vec[0]);

    // Back-to-back transfers: an accept every fourth cycle.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h90; rsp_ready = 1'b1;
    PREADY = 1'b1; PRDATA = 32'h00000055;
    for (int c = 0; c < 12; c++) begin
      chk("b2b_req_ready", 32'(req_ready), 32'((c % 4) == 0));
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'((c % 4) == 3));
      if ((c % 4) == 3) chk("b2b_rdata", rsp_rdata, 32'h55);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0;
    tick();
    chk("b2b_end_idle", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
